// File: rtl/axil_reg_pkg.sv
// Shared types for the AXI-Lite register responder.
// Response codes, FSM states, timeout read data, range check.
package axil_reg_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axil_resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP
  } axil_reg_state_t;

  localparam logic [31:0] AXIL_TIMEOUT_RDATA = 32'hDEAD_BEEF;

  function automatic logic in_range(
    input logic [31:0] addr,
    input int unsigned bits
  );
    return (addr >> bits) == 32'd0;
  endfunction

endpackage

// File: rtl/axil_interface.sv
// AXI-Lite bundle: 32-bit addr/data, 4-bit strb, 2-bit resp.
// master drives AW/W/AR and B/R ready; slave drives the rest.
interface axil_interface;

  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid,
    output bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid,
    input  bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_reg_timer.sv
// Saturating 16-bit access timer shared by read and write paths.
// Ports: clk, rst_n, clear, enable -> expired at count TIMEOUT-1.
module axil_reg_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  logic [15:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != 16'hFFFF) begin
      count <= count + 16'd1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/axil_reg_responder.sv
// AXI-Lite slave to req/ack register port, serialised, timed out.
// Ports: axil_clk, axil_rstn, axil (slave), reg_wr_*, reg_rd_*.
module axil_reg_responder
  import axil_reg_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 axil_clk,
  input  logic                 axil_rstn,
  axil_interface.slave         axil,
  output logic                 reg_wr_req,
  output logic [ADDR_BITS-1:0] reg_wr_addr,
  output logic [31:0]          reg_wr_data,
  output logic [3:0]           reg_wr_strb,
  input  logic                 reg_wr_ack,
  input  logic                 reg_wr_err,
  output logic                 reg_rd_req,
  output logic [ADDR_BITS-1:0] reg_rd_addr,
  input  logic                 reg_rd_ack,
  input  logic [31:0]          reg_rd_data,
  input  logic                 reg_rd_err
);

  axil_reg_state_t state;

  logic        aw_full, w_full, ar_full;
  logic [31:0] aw_addr, w_data, ar_addr;
  logic [3:0]  w_strb;
  logic        last_wr;

  logic aw_take, w_take, ar_take;
  logic aw_nxt, w_nxt, ar_nxt;
  logic aw_free, ar_free;
  logic [31:0] wa_sel, wd_sel, ra_sel;
  logic [3:0]  ws_sel;
  logic wr_avail, rd_avail;
  logic grant_wr, grant_rd;
  logic wr_ok, rd_ok;
  logic wr_done, rd_done;
  logic in_req, expired;

  assign aw_take = axil.awvalid & axil.awready;
  assign w_take  = axil.wvalid & axil.wready;
  assign ar_take = axil.arvalid & axil.arready;

  // Bypass the holders so a fresh beat can be granted the same edge.
  assign wa_sel = aw_full ? aw_addr : axil.awaddr;
  assign wd_sel = w_full ? w_data : axil.wdata;
  assign ws_sel = w_full ? w_strb : axil.wstrb;
  assign ra_sel = ar_full ? ar_addr : axil.araddr;

  assign wr_avail = (aw_full | aw_take) & (w_full | w_take);
  assign rd_avail = ar_full | ar_take;

  assign grant_wr = (state == IDLE) & wr_avail
                  & (~rd_avail | ~last_wr);
  assign grant_rd = (state == IDLE) & rd_avail & ~grant_wr;

  assign wr_ok = in_range(wa_sel, ADDR_BITS);
  assign rd_ok = in_range(ra_sel, ADDR_BITS);

  assign wr_done = (state == WR_REQ) & (reg_wr_ack | expired);
  assign rd_done = (state == RD_REQ) & (reg_rd_ack | expired);

  assign aw_free = wr_done | (grant_wr & ~wr_ok);
  assign ar_free = rd_done | (grant_rd & ~rd_ok);

  assign aw_nxt = (aw_full | aw_take) & ~aw_free;
  assign w_nxt  = (w_full | w_take) & ~aw_free;
  assign ar_nxt = (ar_full | ar_take) & ~ar_free;

  assign in_req = (state == WR_REQ) | (state == RD_REQ);

  axil_reg_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (axil_clk),
    .rst_n   (axil_rstn),
    .clear   (~in_req),
    .enable  (in_req),
    .expired (expired)
  );

  always_ff @(posedge axil_clk or negedge axil_rstn) begin
    if (!axil_rstn) begin
      aw_full      <= 1'b0;
      w_full       <= 1'b0;
      ar_full      <= 1'b0;
      aw_addr      <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      ar_addr      <= '0;
      axil.awready <= 1'b0;
      axil.wready  <= 1'b0;
      axil.arready <= 1'b0;
    end else begin
      aw_full      <= aw_nxt;
      w_full       <= w_nxt;
      ar_full      <= ar_nxt;
      axil.awready <= ~aw_nxt;
      axil.wready  <= ~w_nxt;
      axil.arready <= ~ar_nxt;
      if (aw_take) aw_addr <= axil.awaddr;
      if (w_take) begin
        w_data <= axil.wdata;
        w_strb <= axil.wstrb;
      end
      if (ar_take) ar_addr <= axil.araddr;
    end
  end

  always_ff @(posedge axil_clk or negedge axil_rstn) begin
    if (!axil_rstn) begin
      state       <= IDLE;
      last_wr     <= 1'b0;
      reg_wr_req  <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      reg_wr_strb <= '0;
      reg_rd_req  <= 1'b0;
      reg_rd_addr <= '0;
      axil.bvalid <= 1'b0;
      axil.bresp  <= OKAY;
      axil.rvalid <= 1'b0;
      axil.rresp  <= OKAY;
      axil.rdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // Pointer only moves on contention, so a lone
          // transaction does not steal the other's next turn.
          if (wr_avail && rd_avail) last_wr <= grant_wr;
          if (grant_wr) begin
            if (wr_ok) begin
              state       <= WR_REQ;
              reg_wr_req  <= 1'b1;
              reg_wr_addr <= {wa_sel[ADDR_BITS-1:2], 2'b00};
              reg_wr_data <= wd_sel;
              reg_wr_strb <= ws_sel;
            end else begin
              state       <= WR_RESP;
              axil.bvalid <= 1'b1;
              axil.bresp  <= DECERR;
            end
          end else if (grant_rd) begin
            if (rd_ok) begin
              state       <= RD_REQ;
              reg_rd_req  <= 1'b1;
              reg_rd_addr <= {ra_sel[ADDR_BITS-1:2], 2'b00};
            end else begin
              state       <= RD_RESP;
              axil.rvalid <= 1'b1;
              axil.rresp  <= DECERR;
              axil.rdata  <= '0;
            end
          end
        end
        WR_REQ: begin
          if (wr_done) begin
            state       <= WR_RESP;
            reg_wr_req  <= 1'b0;
            axil.bvalid <= 1'b1;
            axil.bresp  <= (reg_wr_ack && !reg_wr_err)
                         ? OKAY : SLVERR;
          end
        end
        WR_RESP: begin
          if (axil.bready) begin
            state       <= IDLE;
            axil.bvalid <= 1'b0;
          end
        end
        RD_REQ: begin
          if (rd_done) begin
            state       <= RD_RESP;
            reg_rd_req  <= 1'b0;
            axil.rvalid <= 1'b1;
            if (reg_rd_ack) begin
              axil.rresp <= reg_rd_err ? SLVERR : OKAY;
              axil.rdata <= reg_rd_data;
            end else begin
              axil.rresp <= SLVERR;
              axil.rdata <= AXIL_TIMEOUT_RDATA;
            end
          end
        end
        RD_RESP: begin
          if (axil.rready) begin
            state       <= IDLE;
            axil.rvalid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_reg_responder.sv
// Directed bench for axil_reg_responder (ADDR_BITS=12, TIMEOUT=8).
// Drives #1 after posedge, samples there, hand-computed expects.
module tb_axil_reg_responder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wr_req, rd_req;
  logic [11:0] wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_ack = 1'b0, wr_err = 1'b0;
  logic        rd_ack = 1'b0, rd_err = 1'b0;
  logic [31:0] rd_data = '0;

  int vectors = 0;
  int miscompares = 0;

  axil_interface bus ();

  axil_reg_responder #(.ADDR_BITS(12), .TIMEOUT(8)) dut (
    .axil_clk    (clk),
    .axil_rstn   (rstn),
    .axil        (bus),
    .reg_wr_req  (wr_req),
    .reg_wr_addr (wr_addr),
    .reg_wr_data (wr_data),
    .reg_wr_strb (wr_strb),
    .reg_wr_ack  (wr_ack),
    .reg_wr_err  (wr_err),
    .reg_rd_req  (rd_req),
    .reg_rd_addr (rd_addr),
    .reg_rd_ack  (rd_ack),
    .reg_rd_data (rd_data),
    .reg_rd_err  (rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.awaddr  = '0;
    bus.awvalid = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    bus.araddr  = '0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int n;

  initial begin
    idle_bus();
    tick();
    tick();
    chk("rst_awready", 32'(bus.awready), 0);
    chk("rst_wready", 32'(bus.wready), 0);
    chk("rst_arready", 32'(bus.arready), 0);
    chk("rst_bvalid", 32'(bus.bvalid), 0);
    chk("rst_rvalid", 32'(bus.rvalid), 0);
    chk("rst_wr_req", 32'(wr_req), 0);
    chk("rst_rd_req", 32'(rd_req), 0);
    chk("rst_rdata", bus.rdata, 0);
    rstn = 1'b1;
    tick();
    chk("rel_awready", 32'(bus.awready), 1);
    chk("rel_arready", 32'(bus.arready), 1);

    // Write 0x004, ack one cycle after req is seen.
    bus.awaddr = 32'h004; bus.awvalid = 1'b1;
    bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF;
    bus.wvalid = 1'b1;
    tick();
    idle_bus();
    chk("w1_req", 32'(wr_req), 1);
    chk("w1_addr", 32'(wr_addr), 32'h004);
    chk("w1_data", wr_data, 32'h1234_5678);
    chk("w1_strb", 32'(wr_strb), 32'hF);
    chk("w1_awready", 32'(bus.awready), 0);
    tick();
    chk("w1_req2", 32'(wr_req), 1);
    chk("w1_bv_early", 32'(bus.bvalid), 0);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    chk("w1_req_off", 32'(wr_req), 0);
    chk("w1_bvalid", 32'(bus.bvalid), 1);
    chk("w1_bresp", 32'(bus.bresp), 0);
    chk("w1_awready_back", 32'(bus.awready), 1);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    chk("w1_bv_done", 32'(bus.bvalid), 0);

    // W three cycles before AW.
    bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'h3;
    bus.wvalid = 1'b1;
    tick();
    idle_bus();
    chk("w2_wready", 32'(bus.wready), 0);
    chk("w2_noreq_a", 32'(wr_req), 0);
    tick();
    chk("w2_noreq_b", 32'(wr_req), 0);
    tick();
    chk("w2_noreq_c", 32'(wr_req), 0);
    bus.awaddr = 32'h00B; bus.awvalid = 1'b1;
    tick();
    idle_bus();
    chk("w2_req", 32'(wr_req), 1);
    chk("w2_addr", 32'(wr_addr), 32'h008);
    chk("w2_data", wr_data, 32'hCAFE_F00D);
    chk("w2_strb", 32'(wr_strb), 32'h3);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    chk("w2_bvalid", 32'(bus.bvalid), 1);
    chk("w2_bresp", 32'(bus.bresp), 0);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;

    // Write acked with error: same-cycle ack -> SLVERR.
    bus.awaddr = 32'h00C; bus.awvalid = 1'b1;
    bus.wdata = 32'h0000_0001; bus.wstrb = 4'h1;
    bus.wvalid = 1'b1;
    tick();
    idle_bus();
    wr_ack = 1'b1; wr_err = 1'b1;
    tick();
    wr_ack = 1'b0; wr_err = 1'b0;
    chk("w3_bvalid", 32'(bus.bvalid), 1);
    chk("w3_bresp", 32'(bus.bresp), 2);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;

    // Normal read 0x020.
    bus.araddr = 32'h020; bus.arvalid = 1'b1;
    tick();
    idle_bus();
    chk("r1_req", 32'(rd_req), 1);
    chk("r1_addr", 32'(rd_addr), 32'h020);
    rd_ack = 1'b1; rd_data = 32'hA5A5_1234;
    tick();
    rd_ack = 1'b0; rd_data = '0;
    chk("r1_rvalid", 32'(bus.rvalid), 1);
    chk("r1_rdata", bus.rdata, 32'hA5A5_1234);
    chk("r1_rresp", 32'(bus.rresp), 0);
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    chk("r1_rv_done", 32'(bus.rvalid), 0);

    // Read 0x010 with no ack: 8-cycle timeout.
    bus.araddr = 32'h010; bus.arvalid = 1'b1;
    tick();
    idle_bus();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!rd_req) break;
      n++;
      tick();
    end
    chk("to_req_cycles", n, 8);
    chk("to_rvalid", 32'(bus.rvalid), 1);
    chk("to_rresp", 32'(bus.rresp), 2);
    chk("to_rdata", bus.rdata, 32'hDEAD_BEEF);
    rd_ack = 1'b1; rd_data = 32'h1111_1111;
    tick();
    rd_ack = 1'b0; rd_data = '0;
    chk("late_rdata", bus.rdata, 32'hDEAD_BEEF);
    chk("late_rresp", 32'(bus.rresp), 2);
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    tick();
    chk("late_no_req", 32'(rd_req), 0);
    chk("late_no_rv", 32'(bus.rvalid), 0);

    // Out-of-range read 0x1000.
    bus.araddr = 32'h1000; bus.arvalid = 1'b1;
    tick();
    idle_bus();
    chk("dec_no_req", 32'(rd_req), 0);
    chk("dec_rvalid", 32'(bus.rvalid), 1);
    chk("dec_rresp", 32'(bus.rresp), 3);
    chk("dec_rdata", bus.rdata, 0);
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;

    // Arbitration straight out of reset.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    bus.awaddr = 32'h030; bus.awvalid = 1'b1;
    bus.wdata = 32'h0000_0030; bus.wstrb = 4'hF;
    bus.wvalid = 1'b1;
    bus.araddr = 32'h034; bus.arvalid = 1'b1;
    tick();
    idle_bus();
    chk("arb1_wr_first", 32'(wr_req), 1);
    chk("arb1_rd_wait", 32'(rd_req), 0);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    tick();
    chk("arb1_rd_req", 32'(rd_req), 1);
    chk("arb1_rd_addr", 32'(rd_addr), 32'h034);
    rd_ack = 1'b1; rd_data = 32'h0BAD_CAFE;
    tick();
    rd_ack = 1'b0;
    chk("arb1_rdata", bus.rdata, 32'h0BAD_CAFE);
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;

    bus.awaddr = 32'h040; bus.awvalid = 1'b1;
    bus.wdata = 32'h0000_0040; bus.wstrb = 4'hF;
    bus.wvalid = 1'b1;
    bus.araddr = 32'h044; bus.arvalid = 1'b1;
    tick();
    idle_bus();
    chk("arb2_rd_first", 32'(rd_req), 1);
    chk("arb2_wr_wait", 32'(wr_req), 0);
    chk("arb2_rd_addr", 32'(rd_addr), 32'h044);
    rd_ack = 1'b1; rd_data = 32'h0000_0044;
    tick();
    rd_ack = 1'b0;
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    tick();
    chk("arb2_wr_req", 32'(wr_req), 1);
    chk("arb2_wr_addr", 32'(wr_addr), 32'h040);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;

    // Reset while a read request is outstanding.
    bus.araddr = 32'h050; bus.arvalid = 1'b1;
    tick();
    idle_bus();
    chk("mid_rd_req", 32'(rd_req), 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_req", 32'(rd_req), 0);
    chk("mid_rst_rv", 32'(bus.rvalid), 0);
    chk("mid_rst_arrdy", 32'(bus.arready), 0);
    chk("mid_rst_awrdy", 32'(bus.awready), 0);
    tick();
    rstn = 1'b1;
    tick();
    chk("post_arready", 32'(bus.arready), 1);
    chk("post_awready", 32'(bus.awready), 1);
    tick();
    tick();
    chk("post_no_rv", 32'(bus.rvalid), 0);
    chk("post_no_req", 32'(rd_req), 0);
    chk("post_no_bv", 32'(bus.bvalid), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axil_reg_responder.md
# axil_reg_responder

AXI-Lite responder terminating an `axil_interface` slave modport and converting each transaction into a single request/acknowledge access on a simple register port. Sits at the leaf of the control-plane AXI-Lite tree, behind couplers and interconnect, in front of block register files. Serialises reads and writes, range-checks addresses, and bounds every access with a timeout so the bus never hangs.

## Interface
- `ADDR_BITS`, 12: byte-address width of the decoded register space; any set `awaddr`/`araddr` bit at or above this is out of range.
- `TIMEOUT`, 255: cycles to wait for `reg_*_ack` before forcing SLVERR; range 1..65535.
- `axil_clk`  in  1  clock.
- `axil_rstn`  in  1  asynchronous active-low reset.
- `axil`  `axil_interface.slave`  —  AXI-Lite port (32-bit addr, 32-bit data, 4-bit strb, 2-bit resp).
- `reg_wr_req`  out  1  write request, level, held until ack or timeout.
- `reg_wr_addr`  out  ADDR_BITS  word-aligned write address (bits [1:0] forced 0).
- `reg_wr_data`  out  32  write data.
- `reg_wr_strb`  out  4  byte enables.
- `reg_wr_ack`  in  1  write completion, single-cycle.
- `reg_wr_err`  in  1  sampled with ack; 1 → SLVERR.
- `reg_rd_req`  out  1  read request, level, held until ack or timeout.
- `reg_rd_addr`  out  ADDR_BITS  word-aligned read address.
- `reg_rd_ack`  in  1  read completion, single-cycle.
- `reg_rd_data`  in  32  sampled with `reg_rd_ack`.
- `reg_rd_err`  in  1  sampled with ack; 1 → SLVERR.

## Operation
- AW and W captured independently into one-entry holding registers; `awready`/`wready` high while the respective holder is empty. AR likewise via `arready`.
- FSM: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE: write ready when both AW and W held; read ready when AR held. Both ready → round-robin, priority to the type not granted last (after reset: write first).
- Out-of-range address: skip *_REQ, go straight to *_RESP with DECERR (read data 0). No `reg_*_req` issued.
- WR_REQ: `reg_wr_req`=1 until ack (resp OKAY or SLVERR per `reg_wr_err`) or timeout (SLVERR) → WR_RESP. Holders freed on leaving WR_REQ.
- WR_RESP: `bvalid`=1 until `bready`; → IDLE.
- RD_REQ/RD_RESP symmetric; timeout gives SLVERR with `rdata`=32'hDEAD_BEEF; `rdata` registered, stable while `rvalid`.
- Ack arriving when no request is outstanding is ignored.
- Timeout counter: 16 bits, cleared on entry to *_REQ, saturates; fires when count == TIMEOUT−1 without ack; ack on the same cycle wins.

## Timing
- Reset values: all ready/valid/req outputs 0, `bresp`/`rresp` 0, `rdata` 0, addr/data/strb 0, FSM IDLE, holders empty. Readies rise the first cycle after `axil_rstn` deasserts.
- Write: AW and W handshakes complete in cycle N (both same cycle, or the later one at N) → `reg_wr_req` at N+1. Ack at M → `reg_wr_req` low and `bvalid` high at M+1.
- Read: AR at N → `reg_rd_req` at N+1; ack at M → `rvalid` at M+1.
- Minimum write: 3 cycles AW/W→B with same-cycle ack at N+1. DECERR path: `bvalid`/`rvalid` at N+1.
- New AW/W/AR may be accepted while another transaction is in progress; at most one of each held.
- Asynchronous reset mid-transaction: outstanding request dropped immediately, no response issued; register side must tolerate a withdrawn req.

## Structure
- Package `axil_reg_pkg`: `axil_resp_t` (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11), `axil_reg_state_t` FSM enum, `AXIL_TIMEOUT_RDATA`=32'hDEAD_BEEF.
- One sub-module: `axil_reg_timer` (clear, enable, TIMEOUT parameter, `expired` output), instantiated once and shared by read and write paths.

## Test plan
- Write 0x004 ← 0x1234_5678, strb 0xF, ack after 2 cycles → `reg_wr_addr`=0x004, data/strb passed, BRESP OKAY, `bvalid` two cycles after req.
- W handshake 3 cycles before AW → no req until AW; then req next cycle; BRESP OKAY.
- Read 0x1000 with ADDR_BITS=12 → no `reg_rd_req`, RRESP DECERR, `rdata`=0, `rvalid` next cycle.
- Read 0x010, no ack, TIMEOUT=8 → req held 8 cycles, RRESP SLVERR, `rdata`=0xDEAD_BEEF; late ack ignored.
- AW+W and AR presented same cycle from reset → write serviced first, read second; repeat → read first.
- Assert `axil_rstn` low with `reg_rd_req` high → req, `rvalid`, readies 0 immediately; after release readies 1 next cycle, no stale response.
